// File: rtl/alu_pkg.sv
// Shared datapath package: operand widths, Booth FSM states and recoding codes.
package alu_pkg;

    localparam int ALU_WIDTH  = 16;
    localparam int PROD_WIDTH = 2 * ALU_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } booth_state_t;

    // Booth recoding of {q[0], q_m1}: 01 adds M, 10 subtracts M, 00/11 skip.
    localparam logic [1:0] BOOTH_ADD = 2'b01;
    localparam logic [1:0] BOOTH_SUB = 2'b10;

endpackage

// File: rtl/booth_multiplier_if.sv
// Operand / product handshake bundle for the Booth multiplier.
interface booth_multiplier_if
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
);

    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH-1:0]       multiplicand;
    logic [WIDTH-1:0]       multiplier;
    logic                   out_valid;
    logic                   out_ready;
    logic [2*WIDTH-1:0]     product;

    // Operand producer / product consumer side.
    modport master (
        output in_valid, multiplicand, multiplier, out_ready,
        input  in_ready, out_valid, product
    );

    // Multiplier side.
    modport slave (
        input  in_valid, multiplicand, multiplier, out_ready,
        output in_ready, out_valid, product
    );

endinterface

// File: rtl/booth_addsub.sv
// Combinational two's-complement add/subtract stage: sum = sub ? a - b : a + b.
module booth_addsub #(
    parameter int DW = 17
) (
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic          sub,
    output logic [DW-1:0] sum
);

    logic [DW-1:0] b_op;

    // Subtraction is the ~b + 1 negation folded into a single adder carry-in.
    always_comb begin
        b_op = sub ? ~b : b;
        sum  = a + b_op + {{(DW-1){1'b0}}, sub};
    end

endmodule

// File: rtl/booth_multiplier.sv
// Sequential radix-2 Booth signed multiplier, one recoding step per cycle,
// with valid/ready handshakes on operand input and product output.
module booth_multiplier
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    booth_multiplier_if.slave  bus
);

    localparam int             CW        = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]  LAST_STEP = CW'(WIDTH - 1);

    booth_state_t       state_q,   state_d;
    logic [WIDTH:0]     acc_q,     acc_d;
    logic [WIDTH-1:0]   q_q,       q_d;
    logic               q_m1_q,    q_m1_d;
    logic [WIDTH-1:0]   m_q,       m_d;
    logic [CW-1:0]      count_q,   count_d;
    logic [2*WIDTH-1:0] product_q, product_d;

    logic [1:0]         booth_code;
    logic [WIDTH:0]     m_sext;
    logic [WIDTH:0]     addsub_sum;
    logic [WIDTH:0]     step_sel;
    logic [WIDTH:0]     acc_sh;
    logic [WIDTH-1:0]   q_sh;

    assign booth_code = {q_q[0], q_m1_q};
    // One extra accumulator bit keeps A - M exact when M is the most-negative value.
    assign m_sext     = {m_q[WIDTH-1], m_q};

    booth_addsub #(
        .DW (WIDTH + 1)
    ) u_addsub (
        .a   (acc_q),
        .b   (m_sext),
        .sub (q_q[0] & ~q_m1_q),
        .sum (addsub_sum)
    );

    // Booth step result followed by the arithmetic right shift across {acc, q, q_m1}.
    always_comb begin
        step_sel = acc_q;
        if (booth_code == BOOTH_ADD || booth_code == BOOTH_SUB) begin
            step_sel = addsub_sum;
        end
        acc_sh = {step_sel[WIDTH], step_sel[WIDTH:1]};
        q_sh   = {step_sel[0], q_q[WIDTH-1:1]};
    end

    // Next-state and datapath update for IDLE/CALC/DONE.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        q_d       = q_q;
        q_m1_d    = q_m1_q;
        m_d       = m_q;
        count_d   = count_q;
        product_d = product_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    m_d     = bus.multiplicand;
                    q_d     = bus.multiplier;
                    acc_d   = '0;
                    q_m1_d  = 1'b0;
                    count_d = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                acc_d   = acc_sh;
                q_d     = q_sh;
                q_m1_d  = q_q[0];
                count_d = count_q + 1'b1;
                if (count_q == LAST_STEP) begin
                    product_d = {acc_sh[WIDTH-1:0], q_sh};
                    state_d   = DONE;
                end
            end
            DONE: begin
                // The product always spends at least one cycle here, even if
                // out_ready was already high on entry.
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; async reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            q_q       <= '0;
            q_m1_q    <= 1'b0;
            m_q       <= '0;
            count_q   <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            q_q       <= q_d;
            q_m1_q    <= q_m1_d;
            m_q       <= m_d;
            count_q   <= count_d;
            product_q <= product_d;
        end
    end

    // Handshake outputs are pure state decodes.
    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.product   = product_q;

endmodule

// File: doc/booth_multiplier.md
# booth_multiplier

Sequential signed multiplier for the datapath. It multiplies two WIDTH-bit two's-complement operands using radix-2 Booth recoding and returns the full 2·WIDTH-bit product. Each cycle it drives an add/subtract stage with the operand and a `sub` select, then consumes the sum. Operands arrive from the register/operand path on a valid/ready handshake, and the product leaves the same way.

## Interface
- `WIDTH`, default 16: operand width; product is 2·WIDTH.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `in_valid`  in  1: operand pair valid.
- `in_ready`  out  1: block can accept operands; equals (state == IDLE).
- `multiplicand`  in  WIDTH: signed operand M; sampled only on accept.
- `multiplier`  in  WIDTH: signed operand Q; sampled only on accept.
- `out_valid`  out  1: product valid; high only in state DONE.
- `out_ready`  in  1: consumer accepts the product.
- `product`  out  2·WIDTH: signed M·Q, registered.

## Operation
- Internal registers:
  - `acc`: WIDTH+1 bits, sign-extended accumulator, so that A−M never overflows when M = most-negative.
  - `q`: WIDTH bits.
  - `q_m1`: 1 bit.
  - `m`: WIDTH bits.
  - `count`: $clog2(WIDTH)+1 bits.
- States: IDLE, CALC, DONE.
- **IDLE:** on `in_valid && in_ready`:
  - `m` ← multiplicand, `q` ← multiplier, `acc` ← 0, `q_m1` ← 0, `count` ← 0.
  - Next state is CALC.
- **CALC:** one Booth step per cycle on {q[0], q_m1}:
  - 01: `acc` + sext(m).
  - 10: `acc` − sext(m), issued as add with sub=1, i.e. the ~m+1 negation.
  - 00 or 11: `acc` unchanged.
  - The result then shifts arithmetic-right by one across {acc, q, q_m1}; acc's MSB is replicated.
  - `count` increments.
  - On the step where `count == WIDTH-1`, the registered `product` ← {shifted acc[WIDTH-1:0], shifted q}, and the next state is DONE.
- **DONE:** `out_valid` = 1; `product` holds stable.
  - On `out_ready`, the next state is IDLE.
  - If `out_ready` is already high on entry, the product still spends exactly one cycle in DONE.
- No overlap: a new operation can be accepted only after the result handshake, and is accepted at the earliest in the cycle after it.
- `in_valid` in CALC or DONE is ignored. Operand changes outside the accept edge have no effect.
- Arithmetic is modulo 2^(WIDTH+1) in `acc`. The product is exact for every input pair, including (−2^(WIDTH−1))².

## Timing
- Reset (async assert, any state):
  - state = IDLE, all internal registers = 0, `product` = 0.
  - `out_valid` = 0, `in_ready` = 1.
  - An aborted operation never produces `out_valid`.
- Latency: accept on edge E0. CALC steps occur on edges E1..E16. `out_valid` is high from just after E16.
  - For WIDTH = 16 that is 16 cycles from accept to result.
  - The state sequence is IDLE→CALC×16→DONE.
- `out_valid` stays high and `product` is constant until the edge where `out_ready` = 1. After that edge `out_valid` = 0 and `in_ready` = 1.
- `in_ready` and `out_valid` are pure decodes of the state register; there are no combinational paths from inputs to outputs.
- Throughput: at most one product per WIDTH+2 cycles with `out_ready` held high.

## Structure
- Shared package `alu_pkg`:
  - `ALU_WIDTH` = 16.
  - `PROD_WIDTH` = 2·ALU_WIDTH.
  - Booth-state enum `booth_state_t` {IDLE, CALC, DONE}.
  - Booth-code localparams for 2'b01 (add) and 2'b10 (sub).
- Sub-module `booth_addsub`:
  - Combinational WIDTH+1-bit two's-complement add/subtract.
  - Inputs `a`, `b`, `sub`; output `sum`.
  - Semantics: sum = sub ? a + (~b + 1) : a + b.
  - Instantiated once, with a = `acc`, b = sext(m), `sub` = q[0] & ~q_m1.
- FSM, shift register and handshake live in `booth_multiplier`.

## Test plan
- **Basic product and latency:** reset, then accept 3 × 5 → `product` = 0x0000000F. `out_valid` first high exactly 16 cycles after the accept edge; `in_ready` low throughout.
- **Mixed signs:** 0xFFF9 (−7) × 6 → 0xFFFFFFD6 (−42). 0x8000 × 0x7FFF → 0xC0008000.
- **Extreme corner:** 0x8000 × 0x8000 → 0x40000000. 0 × 0x1234 → 0x00000000. 0xFFFF × 0xFFFF → 0x00000001.
- **Backpressure:** hold `out_ready` = 0 for 5 cycles after `out_valid`.
  - `product` stays stable and `in_ready` stays 0.
  - Toggling `in_valid` and operands during the stall has no effect.
  - Raise `out_ready`: one handshake edge, then `in_ready` = 1 the next cycle.
- **Back-to-back:** `in_valid` and `out_ready` tied high over 3 operations → each product correct, with spacing of 18 cycles between accepts.
- **Reset mid-operation:** assert `rst_n` = 0 asynchronously after the 8th CALC step.
  - Immediately `out_valid` = 0, `in_ready` = 1, `product` = 0.
  - A subsequent 0x0100 × 0x0100 returns 0x00010000.
